// File: rtl/down_timer.sv
// Loadable down-counting timer with a prescaler, one-shot or periodic
// operation and a single-cycle expiry pulse. A terminal count is loaded
// through a valid/ready handshake. Counting runs while the timer is in RUN.
// When the count reaches zero the timer either reloads or returns to IDLE.
module down_timer #(
  parameter int TIMER_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [TIMER_WIDTH-1:0]    load_val_i,
  input  logic                      periodic_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [TIMER_WIDTH-1:0]    count_o,
  output logic                      busy_o,
  output logic                      expire_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [TIMER_WIDTH-1:0]    count_q, count_d;
  logic [TIMER_WIDTH-1:0]    reload_q, reload_d;
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
  logic                      expire_q, expire_d;

  logic load_accept;
  logic tick;
  logic last_tick;

  // The handshake depends only on the state, so a requester held off
  // during RUN simply keeps valid asserted until the timer stops.
  assign load_ready_o = (state_q != RUN);
  assign load_accept  = load_valid_i & load_ready_o;

  // A tick fires once the prescaler has reached the programmed divider. Using
  // >= means a divider lowered mid-count ticks at once instead of wrapping.
  assign tick      = (psc_q >= prescale_i);
  assign last_tick = (count_q <= TIMER_WIDTH'(1));

  // Next-state, datapath and expiry decision; clear overrides everything else
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    psc_d    = psc_q;
    expire_d = 1'b0;

    if (clr_i) begin
      state_d  = IDLE;
      count_d  = '0;
      reload_d = '0;
      psc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE, LOADED: begin
          if (load_accept) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            psc_d    = '0;
            state_d  = start_i ? RUN : LOADED;
          end else if (start_i && (state_q == LOADED)) begin
            psc_d   = '0;
            state_d = RUN;
          end
        end

        RUN: begin
          if (stop_i) begin
            psc_d   = '0;
            state_d = LOADED;
          end else if (tick) begin
            psc_d = '0;
            if (last_tick) begin
              expire_d = 1'b1;
              if (periodic_i) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end else begin
              count_d = count_q - TIMER_WIDTH'(1);
            end
          end else begin
            psc_d = psc_q + PRESCALE_WIDTH'(1);
          end
        end

        default: begin
          state_d = IDLE;
          count_d = '0;
          psc_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      psc_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      psc_q    <= psc_d;
      expire_q <= expire_d;
    end
  end

  assign count_o  = count_q;
  assign busy_o   = (state_q == RUN);
  assign expire_o = expire_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer. The stimulus process drives each cycle,
// advances a behavioural timer model and queues the outputs expected after
// the next clock edge. A monitor pops and compares them just after that edge.
module tb_down_timer;

  localparam int TW = 8;
  localparam int PW = 4;

  logic          clk_i;
  logic          rst_ni;
  logic          clr_i;
  logic          load_valid_i;
  logic          load_ready_o;
  logic [TW-1:0] load_val_i;
  logic          periodic_i;
  logic          start_i;
  logic          stop_i;
  logic [PW-1:0] prescale_i;
  logic [TW-1:0] count_o;
  logic          busy_o;
  logic          expire_o;

  down_timer #(.TIMER_WIDTH(TW), .PRESCALE_WIDTH(PW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_val_i   (load_val_i),
    .periodic_i   (periodic_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .prescale_i   (prescale_i),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .expire_o     (expire_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int count;
    int busy;
    int ready;
    int expire;
  } snap_t;

  snap_t expQ[$];

  int checks   = 0;
  int failures = 0;
  int dutExpireCount = 0;

  // Reference timer: "running" plus a count, a reload value and the number
  // of cycles elapsed since the last prescaler tick.
  bit mLoaded;
  bit mRunning;
  int mCount;
  int mReload;
  int mSinceTick;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mLoaded    = 0;
    mRunning   = 0;
    mCount     = 0;
    mReload    = 0;
    mSinceTick = 0;
  endfunction

  // Advance the model by one clock edge using the current inputs. Returns
  // the outputs expected to be visible after that edge.
  function automatic snap_t modelStep();
    snap_t s;
    bit fired = 0;
    if (clr_i) begin
      modelReset();
    end else if (!mRunning) begin
      if (load_valid_i) begin
        mCount     = int'(load_val_i);
        mReload    = int'(load_val_i);
        mLoaded    = 1;
        mSinceTick = 0;
        mRunning   = start_i;
      end else if (start_i && mLoaded) begin
        mSinceTick = 0;
        mRunning   = 1;
      end
    end else if (stop_i) begin
      mRunning   = 0;
      mSinceTick = 0;
    end else if (mSinceTick >= int'(prescale_i)) begin
      mSinceTick = 0;
      if (mCount > 1) begin
        mCount = mCount - 1;
      end else begin
        fired = 1;
        if (periodic_i) begin
          mCount = mReload;
        end else begin
          mCount   = 0;
          mRunning = 0;
          mLoaded  = 0;
        end
      end
    end else begin
      mSinceTick++;
    end
    s.count  = mCount;
    s.busy   = mRunning ? 1 : 0;
    s.ready  = mRunning ? 0 : 1;
    s.expire = fired ? 1 : 0;
    return s;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the prediction
  task automatic applyStimulus(input bit lv, input int val, input bit per,
                               input bit st, input bit sp, input int psc,
                               input bit clr);
    @(negedge clk_i);
    checkOutput("load_ready_pre", int'(load_ready_o), mRunning ? 0 : 1);
    load_valid_i = lv;
    load_val_i   = TW'(val);
    periodic_i   = per;
    start_i      = st;
    stop_i       = sp;
    prescale_i   = PW'(psc);
    clr_i        = clr;
    expQ.push_back(modelStep());
  endtask

  task automatic idleCycles(input int n, input bit per, input int psc);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, per, 0, 0, psc, 0);
  endtask

  // Monitor: compare every registered output just after each rising edge
  initial begin
    snap_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (expire_o) dutExpireCount++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("count_o",      int'(count_o),      e.count);
        checkOutput("busy_o",       int'(busy_o),       e.busy);
        checkOutput("load_ready_o", int'(load_ready_o), e.ready);
        checkOutput("expire_o",     int'(expire_o),     e.expire);
      end
    end
  end

  // Global time bound so the run can never hang
  initial begin
    #2ms;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base;
    rst_ni       = 1'b0;
    clr_i        = 1'b0;
    load_valid_i = 1'b0;
    load_val_i   = '0;
    periodic_i   = 1'b0;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    prescale_i   = '0;
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_count",  int'(count_o),      0);
    checkOutput("reset_busy",   int'(busy_o),       0);
    checkOutput("reset_ready",  int'(load_ready_o), 1);
    checkOutput("reset_expire", int'(expire_o),     0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] one-shot load 3 with start, prescale 0");
    applyStimulus(1, 3, 0, 1, 0, 0, 0);
    idleCycles(5, 0, 0);

    $display("[TB] periodic load 2, prescale 3, three expiries");
    base = dutExpireCount;
    applyStimulus(1, 2, 1, 1, 0, 3, 0);
    idleCycles(24, 1, 3);
    @(posedge clk_i);
    #3;
    checkOutput("periodic_expiries", dutExpireCount - base, 3);
    applyStimulus(0, 0, 1, 0, 1, 3, 0);

    $display("[TB] stop at count 5 then resume");
    applyStimulus(1, 8, 0, 1, 0, 1, 0);
    idleCycles(6, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    idleCycles(3, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    idleCycles(4, 0, 1);

    $display("[TB] load while running is refused, then clear wins");
    applyStimulus(1, 77, 0, 0, 0, 1, 0);
    applyStimulus(1, 99, 0, 1, 0, 1, 1);
    idleCycles(2, 0, 1);

    $display("[TB] load 0 one-shot, then periodic reload 0");
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    idleCycles(3, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 1, 0);
    idleCycles(8, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 1, 1);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1, 6, 0, 1, 0, 0, 0);
    idleCycles(2, 0, 0);
    @(posedge clk_i);
    #3;
    @(negedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_count",  int'(count_o),      0);
    checkOutput("async_rst_busy",   int'(busy_o),       0);
    checkOutput("async_rst_ready",  int'(load_ready_o), 1);
    checkOutput("async_rst_expire", int'(expire_o),     0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    modelReset();
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idleCycles(2, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) < 25),
                    (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                                 : int'($urandom_range(0, 6))),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 99) < 20),
                    ($urandom_range(0, 99) < 5),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 2));
    end

    @(posedge clk_i);
    #3;
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counting timer with prescaler, one-shot/periodic modes and a single-cycle expiry pulse. It is the consumer-side counterpart of the free-running up counter. Software or an FSM loads a terminal count through a valid/ready handshake, starts the timer, and receives expire_o when the count reaches zero. It is used for timeouts, watchdogs and periodic tick generation in the common library.

Parameters:
TIMER_WIDTH, 8, width of load value, reload register and count_o
PRESCALE_WIDTH, 4, width of prescale_i and the internal prescaler counter

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
clr_i  input  1  synchronous clear, highest priority after reset
load_valid_i  input  1  load request
load_ready_o  output  1  load can be accepted this cycle
load_val_i  input  TIMER_WIDTH  value to load (count and reload)
periodic_i  input  1  1 = auto-reload on expiry, 0 = one-shot; sampled at each expiry
start_i  input  1  start/resume counting
stop_i  input  1  pause counting
prescale_i  input  PRESCALE_WIDTH  tick every prescale_i+1 cycles; 0 = every cycle
count_o  output  TIMER_WIDTH  current count
busy_o  output  1  high while in RUN
expire_o  output  1  one-cycle pulse on expiry

Behaviour:
- Reset is controlled by clk_i and rst_ni (asynchronous, active-low). Reset values: state IDLE, count 0, reload 0, prescaler 0, expire_o 0, busy_o 0. load_ready_o = 1.
- States:
  - IDLE: not loaded.
  - LOADED: value held, not counting.
  - RUN: counting.
- load_ready_o = (state != RUN). Loads are combinational on state only. Loads requested during RUN are not accepted; the requester holds valid.
- Accepted load (valid & ready): count <= load_val_i, reload <= load_val_i.
  - From IDLE or LOADED: go to LOADED.
  - If start_i is high in the same cycle: go directly to RUN with the loaded value.
- start_i in LOADED: go to RUN, prescaler <= 0. start_i in IDLE without a load is ignored.
- stop_i in RUN: go to LOADED, count held, prescaler <= 0. A later start resumes from the held count.
- start_i and stop_i together: stop wins in RUN; start wins otherwise.
- Prescaler (RUN only):
  - tick = (psc >= prescale_i). On tick, psc <= 0; otherwise psc <= psc + 1.
  - Lowering prescale_i mid-count causes an immediate tick; there is no long wrap.
- On tick with count > 1: count <= count - 1.
- On tick with count <= 1 (expiry):
  - expire_o <= 1 for exactly one cycle.
  - If periodic_i = 1: count <= reload and stay in RUN.
  - Otherwise: count <= 0 and go to IDLE.
- Reload 0 in periodic mode expires on every tick. Load 0 in one-shot mode expires on the first tick.
- Latency: with start sampled at edge E, prescale P and value N ≥ 1, expire_o is high during the cycle after edge E + N*(P+1). count_o is registered.
- Wrap-around: count never underflows; it saturates at 0 or reloads.
- clr_i: go to IDLE, count/reload/prescaler <= 0, expire_o <= 0. It overrides load, start and tick in the same cycle.
- Asynchronous reset mid-RUN forces all reset values immediately. No expire is generated.
- busy_o = (state == RUN), registered state decode.
- expire_o is never high for two consecutive cycles unless periodic with reload ≤ 1 at prescale 0.

Test Plan:
- Load 3, start same cycle, prescale 0, one-shot -> count_o 3,2,1,0 on successive edges; expire_o high one cycle after the edge where count goes 1->0; busy_o falls with it; state IDLE.
- Load 2, prescale 3, periodic, start -> expire_o every 8 cycles, count reloads to 2 each time; 3 expiries observed.
- RUN with count 5: assert stop_i -> count holds at its value and load_ready_o = 1. Then start -> decrement resumes after prescale_i+1 cycles, with no lost or extra tick.
- load_valid_i during RUN -> load_ready_o = 0 and count unaffected. In the same cycle, clr_i with start_i and load -> count 0, IDLE, expire_o 0.
- Load 0 one-shot, start -> expire_o on first tick, count stays 0. Then periodic with reload 0 -> expire_o on every tick.
- rst_ni asserted mid-RUN (count 4) -> all outputs reach reset values asynchronously, before the next clock edge. After release, start without a load is ignored.
